// File: rtl/sensor_log_mem.sv
// sensor_log_mem: per-channel circular sensor logs held in an external
// memory macro, with a bit-serial (backscatter) read-out path.
//
// Ports
//   clk, reset_n        : clock, asynchronous active-low reset
//   wr_req/wr_ch/wr_data: log-write request (held until wr_ack), wr_ack pulse
//   rd_start/rd_ch/rd_count: one-cycle read command (rd_count 0 = all stored)
//   bit_tick            : bit-rate enable for the serial output
//   tx_bit/tx_bit_valid : serial data, MSB first, oldest word first
//   tx_done, busy       : end-of-read pulse, FSM not idle
//   mem_sel/mem_addr/mem_wdata/mem_rdata/PC_B/WE/SE : memory macro interface
//   count, overflow     : words stored per channel, sticky overwrite flags
module sensor_log_mem #(
  parameter  int N_CH   = 3,
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 64,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_req,
  input  logic [2:0]             wr_ch,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   wr_ack,
  input  logic                   rd_start,
  input  logic [2:0]             rd_ch,
  input  logic [AW:0]            rd_count,
  input  logic                   bit_tick,
  output logic                   tx_bit,
  output logic                   tx_bit_valid,
  output logic                   tx_done,
  output logic                   busy,
  output logic [N_CH-1:0]        mem_sel,
  output logic [AW-1:0]          mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   PC_B,
  output logic                   WE,
  output logic                   SE,
  output logic [N_CH*(AW+1)-1:0] count,
  output logic [N_CH-1:0]        overflow
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BW = $clog2(DATA_W);
  localparam logic [N_CH-1:0] ONE  = 1;
  localparam logic [AW:0]     FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_DONE, S_RD_ADDR, S_RD_DATA, S_SHIFT, S_DONE
  } state_t;

  state_t state, nxt;

  logic [AW:0]       cnt  [N_CH];
  logic [AW-1:0]     wptr [N_CH];
  logic [AW-1:0]     rptr [N_CH];
  logic [CW-1:0]     w_ch, r_ch;
  logic [AW:0]       remaining;
  logic [DATA_W-1:0] sr;
  logic [BW-1:0]     bitcnt;
  logic              rd_active;   // a read is suspended while a write is serviced
  logic [N_CH-1:0]   ovf;

  logic        wr_ok, rd_ok, last_bit;
  logic [AW:0] rd_avail, rd_len, w_newcnt;

  assign wr_ok    = wr_req   && ({1'b0, wr_ch} < 4'(N_CH));
  assign rd_ok    = rd_start && ({1'b0, rd_ch} < 4'(N_CH));
  assign last_bit = bit_tick && (bitcnt == BW'(DATA_W-1));
  assign rd_avail = cnt[rd_ch[CW-1:0]];
  assign rd_len   = (rd_count == '0 || rd_count > rd_avail) ? rd_avail : rd_count;
  assign w_newcnt = (cnt[w_ch] == FULL) ? FULL : cnt[w_ch] + 1'b1;

  for (genvar i = 0; i < N_CH; i++) begin : g_cnt
    assign count[i*(AW+1) +: AW+1] = cnt[i];
  end
  assign overflow = ovf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (wr_ok) nxt = S_WR_ADDR;
                 else if (rd_ok) nxt = S_RD_ADDR;
      S_WR_ADDR: nxt = S_WR_DATA;
      S_WR_DATA: nxt = S_WR_DONE;
      S_WR_DONE: nxt = rd_active ? S_RD_ADDR : S_IDLE;
      // An empty request still passes through RD_ADDR so that tx_done
      // always follows rd_start by the same two cycles.
      S_RD_ADDR: nxt = (remaining == '0) ? S_DONE : S_RD_DATA;
      S_RD_DATA: nxt = S_SHIFT;
      S_SHIFT:   if (last_bit) begin
                   if (remaining == (AW+1)'(1)) nxt = S_DONE;
                   else if (wr_ok)              nxt = S_WR_ADDR;
                   else                         nxt = S_RD_ADDR;
                 end
      S_DONE:    nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i]  <= '0;
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
      w_ch      <= '0;
      r_ch      <= '0;
      remaining <= '0;
      sr        <= '0;
      bitcnt    <= '0;
      rd_active <= 1'b0;
      ovf       <= '0;
    end else begin
      if (nxt == S_WR_ADDR && state != S_WR_ADDR) w_ch <= wr_ch[CW-1:0];
      case (state)
        S_IDLE: if (!wr_ok && rd_ok) begin
          r_ch      <= rd_ch[CW-1:0];
          remaining <= rd_len;
          rd_active <= 1'b1;
        end
        S_WR_DONE: begin
          wptr[w_ch] <= wptr[w_ch] + 1'b1;
          cnt[w_ch]  <= w_newcnt;
          if (cnt[w_ch] == FULL) begin
            rptr[w_ch] <= rptr[w_ch] + 1'b1;   // drop the oldest word
            ovf[w_ch]  <= 1'b1;
          end
          if (rd_active && r_ch == w_ch && remaining > w_newcnt)
            remaining <= w_newcnt;
        end
        S_RD_DATA: begin
          sr     <= mem_rdata;
          bitcnt <= '0;
        end
        S_SHIFT: if (bit_tick) begin
          sr     <= sr << 1;
          bitcnt <= bitcnt + 1'b1;
          if (last_bit) begin
            rptr[r_ch] <= rptr[r_ch] + 1'b1;
            cnt[r_ch]  <= cnt[r_ch] - 1'b1;
            remaining  <= remaining - 1'b1;
          end
        end
        S_DONE: rd_active <= 1'b0;
        default: ;
      endcase
    end
  end

  // Outputs decode straight from state so an asynchronous reset forces
  // them to idle values in the same cycle.
  always_comb begin
    mem_sel      = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    PC_B         = 1'b1;
    WE           = 1'b0;
    SE           = 1'b0;
    wr_ack       = 1'b0;
    tx_bit       = 1'b0;
    tx_bit_valid = 1'b0;
    tx_done      = 1'b0;
    busy         = (state != S_IDLE);
    case (state)
      S_WR_ADDR: begin
        mem_sel  = ONE << w_ch;
        mem_addr = wptr[w_ch];
        PC_B     = 1'b0;
      end
      S_WR_DATA: begin
        mem_sel   = ONE << w_ch;
        mem_addr  = wptr[w_ch];
        mem_wdata = wr_data;
        WE        = 1'b1;
      end
      S_WR_DONE: wr_ack = 1'b1;
      S_RD_ADDR: begin
        mem_sel  = ONE << r_ch;
        mem_addr = rptr[r_ch];
        PC_B     = 1'b0;
      end
      S_RD_DATA: begin
        mem_sel  = ONE << r_ch;
        mem_addr = rptr[r_ch];
        SE       = 1'b1;
      end
      S_SHIFT: begin
        tx_bit_valid = bit_tick;
        tx_bit       = bit_tick & sr[DATA_W-1];
      end
      S_DONE:  tx_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sensor_log_mem.sv
// Scoreboard bench for sensor_log_mem (N_CH 3, DATA_W 16, DEPTH 64).
// Stimulus pushes expected wr_ack / tx_bit / tx_done events into one
// ordered queue; a negedge monitor pops and compares as the DUT emits them.
module tb_sensor_log_mem;
  localparam int N_CH = 3, DW = 16, DEPTH = 64, AW = 6;
  localparam int K_ACK = 0, K_BIT = 1, K_DONE = 2;

  typedef struct { int kind; logic val; } ev_t;

  logic clk = 0, reset_n = 0;
  logic wr_req = 0, rd_start = 0, bit_tick = 0;
  logic [2:0] wr_ch = 0, rd_ch = 0;
  logic [DW-1:0] wr_data = 0, mem_wdata, mem_rdata;
  logic [AW:0] rd_count = 0;
  logic wr_ack, tx_bit, tx_bit_valid, tx_done, busy, PC_B, WE, SE;
  logic [N_CH-1:0] mem_sel, overflow;
  logic [AW-1:0] mem_addr;
  logic [N_CH*(AW+1)-1:0] count;

  int checks = 0, fails = 0;
  ev_t q[$];
  logic [DW-1:0] mem [N_CH][DEPTH];

  sensor_log_mem #(.N_CH(N_CH), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .wr_req(wr_req), .wr_ch(wr_ch), .wr_data(wr_data),
    .wr_ack(wr_ack), .rd_start(rd_start), .rd_ch(rd_ch), .rd_count(rd_count),
    .bit_tick(bit_tick), .tx_bit(tx_bit), .tx_bit_valid(tx_bit_valid), .tx_done(tx_done),
    .busy(busy), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .PC_B(PC_B), .WE(WE), .SE(SE), .count(count), .overflow(overflow));

  always #5 clk = ~clk;

  // memory macro model
  always @(posedge clk)
    if (WE)
      for (int c = 0; c < N_CH; c++)
        if (mem_sel[c]) mem[c][mem_addr] <= mem_wdata;
  always_comb begin
    mem_rdata = '0;
    for (int c = 0; c < N_CH; c++)
      if (mem_sel[c]) mem_rdata = mem[c][mem_addr];
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      bit_tick = ~bit_tick;
    end
  end

  task automatic chk_ev(input int kind, input logic v, input string name);
    checks++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL %s: unexpected event, none queued", name);
    end else begin
      ev_t e;
      e = q.pop_front();
      if (e.kind != kind || (kind == K_BIT && e.val !== v)) begin
        fails++;
        $display("FAIL %s: got kind %0d val %0b, expected kind %0d val %0b",
                 name, kind, v, e.kind, e.val);
      end
    end
  endtask

  always @(negedge clk)
    if (reset_n) begin
      if (wr_ack)       chk_ev(K_ACK, 1'b0, "wr_ack");
      if (tx_bit_valid) chk_ev(K_BIT, tx_bit, "tx_bit");
      if (tx_done)      chk_ev(K_DONE, 1'b0, "tx_done");
    end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic v);
    ev_t e;
    e.kind = kind; e.val = v;
    q.push_back(e);
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    for (int i = DW-1; i >= 0; i--) push(K_BIT, d[i]);
  endtask

  function automatic logic [AW:0] cnt_of(input int ch);
    return count[ch*(AW+1) +: AW+1];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue a write and hold wr_req until wr_ack. With idle=1 the ack is
  // queued here and the 3-cycle latency and the WE strobe are checked.
  task automatic do_write(input int ch, input logic [DW-1:0] d, input bit idle, input bit chk_we);
    int n = 0, we_n = 0;
    logic [AW-1:0] we_addr = '0;
    logic [N_CH-1:0] we_sel = '0;
    if (idle) push(K_ACK, 1'b0);
    wr_req = 1; wr_ch = 3'(ch); wr_data = d;
    do begin
      tick(); n++;
      if (WE) begin we_n++; we_addr = mem_addr; we_sel = mem_sel; end
    end while (!wr_ack && n < 300);
    if (!wr_ack) check("wr_ack_timeout", 0, 1);
    if (idle) check("wr_latency", n, 3);
    if (chk_we) begin
      check("we_cycles", we_n, 1);
      check("we_addr", we_addr, 0);
      check("we_sel", we_sel, 3'b010);
    end
    wr_req = 0;
    tick();
  endtask

  task automatic start_read(input int ch, input int cnt);
    rd_start = 1; rd_ch = 3'(ch); rd_count = (AW+1)'(cnt);
    tick();
    rd_start = 0;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 1;   // start_read already spent one cycle
    while (!tx_done && n < bound) begin tick(); n++; end
    if (!tx_done) check("tx_done_timeout", 0, 1);
    tick();
  endtask

  initial begin
    int n;
    // ---- reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_pcb", PC_B, 1);
    check("rst_we_se", {WE, SE, wr_ack, tx_done, tx_bit_valid}, 0);
    check("rst_mem", {mem_sel, mem_addr, mem_wdata}, 0);
    check("rst_count", count, 0);
    check("rst_ovf", overflow, 0);
    @(negedge clk); reset_n = 1;
    tick();

    // ---- single write to ch1
    do_write(1, 16'hA501, 1, 1);
    check("cnt1_after_wr", cnt_of(1), 1);

    // ---- two words to ch0, full read
    do_write(0, 16'h1234, 1, 0);
    do_write(0, 16'h5678, 1, 0);
    push_word(16'h1234); push_word(16'h5678); push(K_DONE, 1'b0);
    start_read(0, 0);
    wait_done(2000, n);
    check("cnt0_after_rd", cnt_of(0), 0);

    // ---- empty read, then invalid channel
    push(K_DONE, 1'b0);
    start_read(0, 0);
    wait_done(20, n);
    check("empty_rd_latency", n, 2);
    start_read(5, 0);
    check("bad_ch_busy", busy, 0);
    tick();
    check("bad_ch_busy2", busy, 0);

    // ---- write to ch0 serviced between the two words of a ch1 read
    do_write(1, 16'hBEEF, 1, 0);
    push_word(16'hA501); push(K_ACK, 1'b0); push_word(16'hBEEF); push(K_DONE, 1'b0);
    start_read(1, 0);
    repeat (8) tick();
    do_write(0, 16'h7777, 0, 0);
    wait_done(2000, n);
    check("cnt1_mid_rd", cnt_of(1), 0);
    check("cnt0_mid_wr", cnt_of(0), 1);
    push_word(16'h7777); push(K_DONE, 1'b0);
    start_read(0, 0);
    wait_done(2000, n);

    // ---- overflow on ch2
    for (int i = 0; i < DEPTH + 2; i++) do_write(2, 16'(i), 1, 0);
    check("cnt2_full", cnt_of(2), DEPTH);
    check("ovf", overflow, 3'b100);
    for (int i = 2; i < DEPTH + 2; i++) push_word(16'(i));
    push(K_DONE, 1'b0);
    start_read(2, 0);
    wait_done(5000, n);
    check("cnt2_drained", cnt_of(2), 0);
    check("ovf_sticky", overflow, 3'b100);

    // ---- partial read
    do_write(0, 16'h0011, 1, 0);
    do_write(0, 16'h0022, 1, 0);
    do_write(0, 16'h0033, 1, 0);
    push_word(16'h0011); push_word(16'h0022); push(K_DONE, 1'b0);
    start_read(0, 2);
    wait_done(2000, n);
    check("cnt0_partial", cnt_of(0), 1);

    // ---- reset during WR_DATA
    wr_req = 1; wr_ch = 0; wr_data = 16'hDEAD;
    tick(); tick();
    check("in_wr_data", WE, 1);
    reset_n = 0; #1;
    check("rst_mid_we", {WE, SE, busy, wr_ack}, 0);
    check("rst_mid_pcb", PC_B, 1);
    check("rst_mid_count", count, 0);
    check("rst_mid_ovf", overflow, 0);
    wr_req = 0;
    @(negedge clk); reset_n = 1;
    repeat (6) begin
      tick();
      check("no_ack_after_rst", wr_ack, 0);
    end
    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
